// File: rtl/channel_merge_rr_pkg.sv
// Shared types and defaults for the round-robin channel merger.
package merge_pkg;
    localparam int NUM_CH_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int CH_ID_W    = $clog2(NUM_CH_DEF);

    typedef logic [CH_ID_W-1:0] ch_id_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        ch_id_t                id;
        logic                  last;
    } merge_beat_t;
endpackage

// File: rtl/channel_merge_rr_if.sv
// Handshake bundle of the merger: NUM_CH input streams plus the merged output stream.
interface channel_merge_rr_if
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int NUM_CH     = NUM_CH_DEF
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_WIDTH-1:0] channel_in_i;
    logic [NUM_CH-1:0]            valid_i;
    logic [NUM_CH-1:0]            last_i;
    logic [NUM_CH-1:0]            ready_o;
    logic [DATA_WIDTH-1:0]        channel_out_o;
    logic [ID_W-1:0]              channel_id_o;
    logic                         last_o;
    logic                         valid_o;
    logic                         ready_i;

    // slave: the merger itself; master: the producers and sink around it
    modport slave (
        input  channel_in_i, valid_i, last_i, ready_i,
        output ready_o, channel_out_o, channel_id_o, last_o, valid_o
    );
    modport master (
        output channel_in_i, valid_i, last_i, ready_i,
        input  ready_o, channel_out_o, channel_id_o, last_o, valid_o
    );
endinterface

// File: rtl/channel_merge_rr_arbiter.sv
// Combinational round-robin grant: first requester at or above the pointer, modulo NUM_CH.
module rr_arbiter
    import merge_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    localparam int ID_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [ID_W-1:0]   ptr_i,
    input  logic              lock_i,
    input  logic [ID_W-1:0]   lock_id_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [ID_W-1:0]   gnt_id_o,
    output logic              gnt_valid_o
);
    logic [NUM_CH-1:0] req_eff;

    // While locked, only the locked channel may compete
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
            assign req_eff[gi] = req_i[gi] & (~lock_i | (lock_id_i == ID_W'(gi)));
        end
    endgenerate

    // Descending scan so the smallest offset from the pointer is written last and wins
    always_comb begin
        logic [ID_W-1:0] idx;
        idx         = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr_i + ID_W'(i);
            if (req_eff[idx]) begin
                gnt_id_o    = idx;
                gnt_valid_o = 1'b1;
            end
        end
        gnt_o           = '0;
        gnt_o[gnt_id_o] = gnt_valid_o;
    end
endmodule

// File: rtl/channel_merge_rr.sv
// Round-robin NUM_CH:1 stream merger with a 1-deep output register tagged by source id.
// Optional packet lock (whole packets stay contiguous) is enabled by defining MERGE_PKT_LOCK_EN.
module channel_merge_rr
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int NUM_CH     = NUM_CH_DEF
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    channel_merge_rr_if.slave    bus
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [NUM_CH-1:0]     gnt;
    logic [ID_W-1:0]       gnt_id;
    logic                  gnt_valid;
    logic                  load;
    logic                  take;
    logic                  lock_w;
    logic [ID_W-1:0]       lock_id_w;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [ID_W-1:0]       id_q,    id_d;
    logic                  last_q,  last_d;
    logic [ID_W-1:0]       ptr_q,   ptr_d;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data[gi] = bus.channel_in_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i       (bus.valid_i),
        .ptr_i       (ptr_q),
        .lock_i      (lock_w),
        .lock_id_i   (lock_id_w),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    // Register may take a new beat when empty or being drained this cycle
    assign load = ~valid_q | bus.ready_i;
    assign take = load & gnt_valid & arstn_i;

    assign bus.ready_o       = gnt & {NUM_CH{load & arstn_i}};
    assign bus.valid_o       = valid_q;
    assign bus.channel_out_o = data_q;
    assign bus.channel_id_o  = id_q;
    assign bus.last_o        = last_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        ptr_d   = ptr_q;
        if (take) begin
            valid_d = 1'b1;
            data_d  = ch_data[gnt_id];
            id_d    = gnt_id;
            last_d  = bus.last_i[gnt_id];
            ptr_d   = gnt_id + ID_W'(1);
        end else if (bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MERGE_PKT_LOCK_EN
    logic            lock_q, lock_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    // A non-last beat opens a lock; the same channel's last beat releases it
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (take) begin
            lock_d    = ~bus.last_i[gnt_id];
            lock_id_d = gnt_id;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    assign lock_w    = lock_q;
    assign lock_id_w = lock_id_q;
`else
    assign lock_w    = 1'b0;
    assign lock_id_w = '0;
`endif
endmodule

// File: tb/tb_channel_merge_rr.sv
// Scoreboard bench for channel_merge_rr: directed scenarios plus randomized traffic vs. a queue-based model.
module tb_channel_merge_rr;
    import merge_pkg::*;

    localparam int N  = 8;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } src_beat_t;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    channel_merge_rr_if #(.DATA_WIDTH(DW), .NUM_CH(N)) bus ();

    channel_merge_rr #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (bus.slave)
    );

    src_beat_t   src_q [N][$];
    merge_beat_t sb_q[$];
    ch_id_t      id_log[$];
    int checks = 0;
    int errors = 0;

    // Model state: output register occupancy, fairness pointer, packet lock
    bit m_valid   = 1'b0;
    int m_ptr     = 0;
    bit m_lock    = 1'b0;
    int m_lock_id = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input int ch, input logic [DW-1:0] d, input bit l);
        src_beat_t b;
        b.data = d;
        b.last = l;
        src_q[ch].push_back(b);
    endtask

    // One clock cycle: drive producers/sink, predict the grant, then advance to the next negedge
    task automatic step(input bit rdy, input logic [N-1:0] mask);
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        int g;
        int k;
        bit load;
        merge_beat_t e;
        for (int c = 0; c < N; c++) begin
            v[c] = (src_q[c].size() > 0) && mask[c];
            bus.channel_in_i[c*DW +: DW] = v[c] ? src_q[c][0].data : $urandom;
            bus.last_i[c] = v[c] ? src_q[c][0].last : 1'($urandom_range(0, 1));
        end
        bus.valid_i = v;
        bus.ready_i = rdy;
        #1;
        load = !m_valid || rdy;
        g = -1;
        if (load) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (g < 0 && v[k] && (!m_lock || k == m_lock_id)) g = k;
            end
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        chk("ready_o", 64'(bus.ready_o), 64'(exp_rdy));
        chk("valid_o", 64'(bus.valid_o), 64'(m_valid));
        if (g >= 0) begin
            e.data = src_q[g][0].data;
            e.id   = ch_id_t'(g);
            e.last = src_q[g][0].last;
            sb_q.push_back(e);
`ifdef MERGE_PKT_LOCK_EN
            m_lock    = !src_q[g][0].last;
            m_lock_id = g;
`endif
            void'(src_q[g].pop_front());
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asserted off the clock edge so the asynchronous clear is observed directly
    task automatic do_reset();
        bus.valid_i = '1;
        bus.ready_i = 1'b0;
        #3 arstn = 1'b0;
        #1;
        chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
        chk("rst_data", 64'(bus.channel_out_o), 64'd0);
        chk("rst_id", 64'(bus.channel_id_o), 64'd0);
        chk("rst_last", 64'(bus.last_o), 64'd0);
        chk("rst_ready_o", 64'(bus.ready_o), 64'd0);
        sb_q.delete();
        for (int c = 0; c < N; c++) src_q[c].delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_lock  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_hold", 64'(bus.ready_o), 64'd0);
        bus.valid_i = '0;
        arstn = 1'b1;
    endtask

    // Monitor: every presented beat must match the oldest expected beat; pop on transfer
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (arstn && bus.valid_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got beat id %0d data %0h expected no beat", bus.channel_id_o, bus.channel_out_o);
                end else begin
                    chk("out_data", 64'(bus.channel_out_o), 64'(sb_q[0].data));
                    chk("out_id", 64'(bus.channel_id_o), 64'(sb_q[0].id));
                    chk("out_last", 64'(bus.last_o), 64'(sb_q[0].last));
                    if (bus.ready_i) begin
                        id_log.push_back(bus.channel_id_o);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int busy;
        bus.channel_in_i = '0;
        bus.valid_i      = '0;
        bus.last_i       = '0;
        bus.ready_i      = 1'b0;
        @(negedge clk);
        do_reset();

        // Single beat on ch0 appears one cycle after acceptance
        add(0, 32'hA5A5_0000, 1'b1);
        step(1'b1, 8'h01);
        chk("t1_valid", 64'(bus.valid_o), 64'd1);
        chk("t1_data", 64'(bus.channel_out_o), 64'hA5A5_0000);
        chk("t1_id", 64'(bus.channel_id_o), 64'd0);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);

        // ch2 held under backpressure, ch5 follows once the sink accepts
        id_log.delete();
        add(2, $urandom, 1'b1);
        add(5, $urandom, 1'b1);
        step(1'b1, 8'h24);
        repeat (3) step(1'b0, 8'h24);
        step(1'b1, 8'h24);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        chk("t3_cnt", 64'(id_log.size()), 64'd2);
        if (id_log.size() == 2) begin
            chk("t3_id0", 64'(id_log[0]), 64'd2);
            chk("t3_id1", 64'(id_log[1]), 64'd5);
        end

        // Pointer wrap: ch7 then ch0
        id_log.delete();
        add(7, $urandom, 1'b1);
        step(1'b1, 8'h80);
        add(0, $urandom, 1'b1);
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        chk("t4_cnt", 64'(id_log.size()), 64'd2);
        if (id_log.size() == 2) begin
            chk("t4_id0", 64'(id_log[0]), 64'd7);
            chk("t4_id1", 64'(id_log[1]), 64'd0);
        end

        // 3-beat packet on ch3 competing with ch4
        id_log.delete();
        add(3, $urandom, 1'b0);
        add(3, $urandom, 1'b0);
        add(3, $urandom, 1'b1);
        add(4, $urandom, 1'b1);
        add(4, $urandom, 1'b1);
        repeat (5) step(1'b1, 8'h18);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        chk("t5_cnt", 64'(id_log.size()), 64'd5);
        if (id_log.size() == 5) begin
`ifdef MERGE_PKT_LOCK_EN
            chk("t5_id0", 64'(id_log[0]), 64'd3);
            chk("t5_id1", 64'(id_log[1]), 64'd3);
            chk("t5_id2", 64'(id_log[2]), 64'd3);
            chk("t5_id3", 64'(id_log[3]), 64'd4);
`else
            chk("t5_id0", 64'(id_log[0]), 64'd3);
            chk("t5_id1", 64'(id_log[1]), 64'd4);
            chk("t5_id2", 64'(id_log[2]), 64'd3);
            chk("t5_id3", 64'(id_log[3]), 64'd4);
            chk("t5_id4", 64'(id_log[4]), 64'd3);
`endif
        end

        // Reset while an output beat is pending
        add(1, $urandom, 1'b1);
        step(1'b1, 8'h02);
        step(1'b0, 8'h00);
        do_reset();

        // All channels valid from pointer 0: ids 0..7,0 back to back
        id_log.delete();
        for (int c = 0; c < N; c++) begin
            add(c, $urandom, 1'b1);
            add(c, $urandom, 1'b1);
        end
        repeat (16) step(1'b1, 8'hFF);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        chk("t2_cnt", 64'(id_log.size()), 64'd16);
        if (id_log.size() >= 9) begin
            for (int i = 0; i < 9; i++) chk("t2_id", 64'(id_log[i]), 64'(i % N));
        end

        // Randomized traffic with packets of 1..3 beats and random backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (src_q[c].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) add(c, $urandom, (b == len - 1));
                end
            end
            if (cyc == 1500) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, N'($urandom));
            end
        end

        // Drain within a bounded number of cycles
        for (int i = 0; i < 200; i++) begin
            busy = sb_q.size();
            for (int c = 0; c < N; c++) busy += src_q[c].size();
            if (busy == 0 && !bus.valid_o) break;
            step(1'b1, '1);
        end
        busy = 0;
        for (int c = 0; c < N; c++) busy += src_q[c].size();
        chk("drain_src", 64'(busy), 64'd0);
        chk("drain_sb", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
